// File: rtl/mem_fifo.sv
// Synchronous FIFO over an inferred single-clock RAM with registered flags and error pulses.
// Optional occupancy output `level` is built when MEM_FIFO_LEVEL_EN is defined.
module mem_fifo #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_BITS    = 10,
    parameter int AFULL_THRESH = 2**ADDR_BITS - 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  overflow,
    output logic                  underflow
`ifdef MEM_FIFO_LEVEL_EN
    ,
    output logic [ADDR_BITS:0]    level
`endif
);

    localparam int                DEPTH     = 2**ADDR_BITS;
    localparam logic [ADDR_BITS:0] DEPTH_CNT = (ADDR_BITS+1)'(DEPTH);
    localparam logic [ADDR_BITS:0] AFULL_CNT = (ADDR_BITS+1)'(AFULL_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_BITS-1:0]  wr_ptr;
    logic [ADDR_BITS-1:0]  rd_ptr;
    logic [ADDR_BITS:0]    count;
    logic [ADDR_BITS:0]    count_next;
    logic                  wr_acc;
    logic                  rd_acc;

    // Acceptance uses the registered flags, so a full FIFO can still read and an empty one still write.
    always_comb begin
        wr_acc     = wr_en && !full;
        rd_acc     = rd_en && !empty;
        count_next = count;
        if (wr_acc && !rd_acc) begin
            count_next = count + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_next = count - 1'b1;
        end
    end

    // RAM array kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            dout        <= '0;
            dout_valid  <= 1'b0;
            full        <= 1'b0;
            empty       <= 1'b1;
            almost_full <= (AFULL_THRESH == 0);
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
                dout   <= mem[rd_ptr];
            end
            dout_valid  <= rd_acc;
            count       <= count_next;
            full        <= (count_next == DEPTH_CNT);
            empty       <= (count_next == '0);
            almost_full <= (count_next >= AFULL_CNT);
            overflow    <= wr_en && full;
            underflow   <= rd_en && empty;
        end
    end

`ifdef MEM_FIFO_LEVEL_EN
    assign level = count;
`endif

endmodule

// File: tb/tb_mem_fifo.sv
// Self-checking bench for mem_fifo: a cycle model with a data scoreboard checks every output each cycle,
// plus a vector table for the basic sequence and explicit checks at the flag boundaries.
module tb_mem_fifo;

    localparam int DEPTH = 1024;
    localparam int AFULL = DEPTH - 4;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] din;
    logic [7:0] dout;
    logic       dout_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       overflow;
    logic       underflow;
`ifdef MEM_FIFO_LEVEL_EN
    logic [10:0] level;
`endif

    mem_fifo #(
        .DATA_WIDTH(8),
        .ADDR_BITS(10),
        .AFULL_THRESH(AFULL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .din(din),
        .rd_en(rd_en),
        .dout(dout),
        .dout_valid(dout_valid),
        .full(full),
        .empty(empty),
        .almost_full(almost_full),
        .overflow(overflow),
        .underflow(underflow)
`ifdef MEM_FIFO_LEVEL_EN
        ,
        .level(level)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic       rd;
        logic [7:0] din;
        logic [7:0] exp_dout;
        logic       exp_valid;
        logic       exp_empty;
        logic       exp_full;
        logic       exp_ovf;
        logic       exp_udf;
    } vec_t;

    vec_t       vecs [9];
    int         checks = 0;
    int         errors = 0;

    // Reference model state; the scoreboard holds words written but not yet read.
    int         m_count;
    logic [7:0] m_dout;
    logic       e_valid;
    logic       e_ovf;
    logic       e_udf;
    logic [7:0] sb [$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at time %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one cycle, advances the model across the edge, then checks every output.
    task automatic applyStimulus(input logic r, input logic w, input logic rd, input logic [7:0] d);
        logic wa;
        logic ra;
        @(negedge clk);
        rst   = r;
        wr_en = w;
        rd_en = rd;
        din   = d;
        @(posedge clk);
        if (r) begin
            m_count = 0;
            m_dout  = 8'h00;
            e_valid = 1'b0;
            e_ovf   = 1'b0;
            e_udf   = 1'b0;
            sb.delete();
        end else begin
            wa      = w && (m_count != DEPTH);
            ra      = rd && (m_count != 0);
            e_ovf   = w && !wa;
            e_udf   = rd && !ra;
            e_valid = ra;
            if (ra) m_dout = sb.pop_front();
            if (wa) sb.push_back(d);
            m_count = m_count + int'(wa) - int'(ra);
        end
        #1;
        checkOutput("dout",        32'(dout),        32'(m_dout));
        checkOutput("dout_valid",  32'(dout_valid),  32'(e_valid));
        checkOutput("empty",       32'(empty),       32'(m_count == 0));
        checkOutput("full",        32'(full),        32'(m_count == DEPTH));
        checkOutput("almost_full", 32'(almost_full), 32'(m_count >= AFULL));
        checkOutput("overflow",    32'(overflow),    32'(e_ovf));
        checkOutput("underflow",   32'(underflow),   32'(e_udf));
`ifdef MEM_FIFO_LEVEL_EN
        checkOutput("level",       32'(level),       32'(m_count));
`endif
    endtask

    initial begin
        rst   = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = 8'h00;
        m_count = 0;
        m_dout  = 8'h00;
        e_valid = 1'b0;
        e_ovf   = 1'b0;
        e_udf   = 1'b0;

        //          wr    rd    din    dout   valid empty full  ovf   udf
        vecs[0] = '{1'b1, 1'b0, 8'h11, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 8'h22, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 8'h33, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 8'h00, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 8'h00, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 8'h00, 8'h33, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 8'h00, 8'h33, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 8'hA5, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 1'b1, 8'h00, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        $display("[TB] reset");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("reset_empty", 32'(empty), 32'd1);
        checkOutput("reset_full",  32'(full),  32'd0);
        checkOutput("reset_dout",  32'(dout),  32'd0);

        $display("[TB] vector table");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, vecs[i].wr, vecs[i].rd, vecs[i].din);
            checkOutput("vec_dout",  32'(dout),       32'(vecs[i].exp_dout));
            checkOutput("vec_valid", 32'(dout_valid), 32'(vecs[i].exp_valid));
            checkOutput("vec_empty", 32'(empty),      32'(vecs[i].exp_empty));
            checkOutput("vec_full",  32'(full),       32'(vecs[i].exp_full));
            checkOutput("vec_ovf",   32'(overflow),   32'(vecs[i].exp_ovf));
            checkOutput("vec_udf",   32'(underflow),  32'(vecs[i].exp_udf));
        end

        $display("[TB] fill to full");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 8'(i));
            if (i == AFULL - 2) checkOutput("afull_before_thresh", 32'(almost_full), 32'd0);
            if (i == AFULL - 1) checkOutput("afull_at_thresh",     32'(almost_full), 32'd1);
            if (i == DEPTH - 2) checkOutput("full_before_last",    32'(full),        32'd0);
        end
        checkOutput("full_after_fill", 32'(full), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'hEE);
        checkOutput("overflow_on_full_write", 32'(overflow), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("overflow_one_cycle", 32'(overflow), 32'd0);

        $display("[TB] full with read and write");
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h77);
        checkOutput("full_rw_overflow", 32'(overflow), 32'd1);
        checkOutput("full_rw_dout",     32'(dout),     32'h00);
        checkOutput("full_rw_full",     32'(full),     32'd0);
`ifdef MEM_FIFO_LEVEL_EN
        checkOutput("full_rw_level",    32'(level),    32'd1023);
`endif
        for (int i = 1; i < DEPTH; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        end
        checkOutput("drained_empty", 32'(empty), 32'd1);
        checkOutput("drained_last",  32'(dout),  32'hFF);

        $display("[TB] pointer wrap at occupancy 5");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'h40 + i));
        end
        for (int i = 0; i < 2000; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 8'($urandom_range(0, 255)));
        end
        checkOutput("wrap_not_empty", 32'(empty), 32'd0);

        $display("[TB] reset with 7 words stored");
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h5A);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h5B);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("rst_mid_empty", 32'(empty), 32'd1);
        checkOutput("rst_mid_full",  32'(full),  32'd0);
        checkOutput("rst_mid_dout",  32'(dout),  32'd0);
`ifdef MEM_FIFO_LEVEL_EN
        checkOutput("rst_mid_level", 32'(level), 32'd0);
`endif
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        checkOutput("rst_mid_underflow", 32'(underflow), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
